// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, state
// encodings, AluOp classes and the control output bundle.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_imm_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decode for the control FSM; only IRWrite/PCWrite in FETCH
// look at MemReady, and reset forces every write strobe low.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e i_state,
    input  logic   i_mem_ready,
    input  logic   i_reset,
    input  logic   i_op_legal,
    output ctrl_t  o_ctrl
);

    always_comb begin
        // NOTE: whole bundle defaults to 0 first so no path through the case infers a latch.
        o_ctrl = '0;
        if (i_reset) begin
            o_ctrl.alu_src_b = 2'b01;
            o_ctrl.alu_op    = ALUOP_ADD;
        end else begin
            unique case (i_state)
                S_FETCH: begin
                    o_ctrl.alu_src_b = 2'b01;
                    o_ctrl.alu_op    = ALUOP_ADD;
                    o_ctrl.ir_write  = i_mem_ready;
                    o_ctrl.pc_write  = i_mem_ready;
                end
                S_DECODE: begin
                    o_ctrl.alu_src_b = 2'b11;
                    o_ctrl.alu_op    = ALUOP_ADD;
                    o_ctrl.illegal   = ~i_op_legal;
                end
                S_MEMADR: begin
                    o_ctrl.alu_src_a = 1'b1;
                    o_ctrl.alu_src_b = 2'b10;
                    o_ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEMRD:  o_ctrl.iord = 1'b1;
                S_MEMWB: begin
                    o_ctrl.mem_to_reg = 1'b1;
                    o_ctrl.reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    o_ctrl.iord      = 1'b1;
                    o_ctrl.mem_write = 1'b1;
                end
                S_RTEXEC: begin
                    o_ctrl.alu_src_a = 1'b1;
                    o_ctrl.alu_src_b = 2'b00;
                    o_ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_RTWB: begin
                    o_ctrl.reg_dst   = 1'b1;
                    o_ctrl.reg_write = 1'b1;
                end
                S_BRANCH: begin
                    o_ctrl.alu_src_a = 1'b1;
                    o_ctrl.alu_src_b = 2'b00;
                    o_ctrl.alu_op    = ALUOP_SUB;
                    o_ctrl.pc_src    = 2'b01;
                    o_ctrl.branch    = 1'b1;
                end
                S_IEXEC: begin
                    o_ctrl.alu_src_a = 1'b1;
                    o_ctrl.alu_src_b = 2'b10;
                    o_ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_IWB:    o_ctrl.reg_write = 1'b1;
                S_JUMP: begin
                    o_ctrl.pc_src   = 2'b10;
                    o_ctrl.pc_write = 1'b1;
                end
                default:  o_ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control: state register plus next-state logic;
// the output map lives in mc_ctrl_outdec.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       MemReady,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] AluOp,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       Branch,
    output logic       Illegal
);

    state_e r_state;
    state_e w_next;
    logic   w_op_legal;
    ctrl_t  w_ctrl;
    logic   w_unused_zero;

    // Zero qualifies Branch outside this block.
    assign w_unused_zero = Zero;

    assign w_op_legal = (Op == OP_RTYPE) || (Op == OP_LW) || (Op == OP_SW) ||
                        (Op == OP_BEQ) || (Op == OP_J) || is_imm_op(Op);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH:  if (MemReady) w_next = S_DECODE;
            S_DECODE: begin
                if ((Op == OP_LW) || (Op == OP_SW)) w_next = S_MEMADR;
                else if (Op == OP_RTYPE)           w_next = S_RTEXEC;
                else if (Op == OP_BEQ)             w_next = S_BRANCH;
                else if (is_imm_op(Op))            w_next = S_IEXEC;
                else if (Op == OP_J)               w_next = S_JUMP;
                else                               w_next = S_FETCH;
            end
            S_MEMADR: w_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (MemReady) w_next = S_MEMWB;
            S_MEMWR:  if (MemReady) w_next = S_FETCH;
            S_RTEXEC: w_next = S_RTWB;
            S_IEXEC:  w_next = S_IWB;
            default:  w_next = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .i_state     (r_state),
        .i_mem_ready (MemReady),
        .i_reset     (reset),
        .i_op_legal  (w_op_legal),
        .o_ctrl      (w_ctrl)
    );

    assign IorD     = w_ctrl.iord;
    assign MemWrite = w_ctrl.mem_write;
    assign IRWrite  = w_ctrl.ir_write;
    assign RegDst   = w_ctrl.reg_dst;
    assign MemtoReg = w_ctrl.mem_to_reg;
    assign RegWrite = w_ctrl.reg_write;
    assign AluSrcA  = w_ctrl.alu_src_a;
    assign AluSrcB  = w_ctrl.alu_src_b;
    assign AluOp    = w_ctrl.alu_op;
    assign PCSrc    = w_ctrl.pc_src;
    assign PCWrite  = w_ctrl.pc_write;
    assign Branch   = w_ctrl.branch;
    assign Illegal  = w_ctrl.illegal;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed cycle-by-cycle bench for mc_ctrl_fsm: each step names the state the
// FSM must be in, and the full output vector is checked through a scoreboard.
module tb_mc_ctrl_fsm;

    typedef enum int {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
        T_RTEXEC, T_RTWB, T_BRANCH, T_IEXEC, T_IWB, T_JUMP
    } tst_e;

    typedef struct {
        string       tag;
        logic [15:0] vec;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Op = 6'd0;
    logic       MemReady = 1'b0;
    logic       Zero = 1'b0;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, AluSrcA;
    logic [1:0] AluSrcB, AluOp, PCSrc;
    logic       PCWrite, Branch, Illegal;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_n = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .AluSrcA(AluSrcA),
        .AluSrcB(AluSrcB), .AluOp(AluOp), .PCSrc(PCSrc), .PCWrite(PCWrite),
        .Branch(Branch), .Illegal(Illegal)
    );

    // Vector order: IorD MemWrite IRWrite RegDst MemtoReg RegWrite AluSrcA
    // AluSrcB[1:0] AluOp[1:0] PCSrc[1:0] PCWrite Branch Illegal
    function automatic logic [15:0] exp_vec(input tst_e st, input logic mr,
                                            input logic rst, input logic ill);
        logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0;
        logic [1:0] sb = 2'b00, aop = 2'b00, pcs = 2'b00;
        logic pcw = 0, br = 0, il = 0;
        if (rst) begin
            sb = 2'b01;
        end else begin
            case (st)
                T_FETCH:  begin sb = 2'b01; irw = mr; pcw = mr; end
                T_DECODE: begin sb = 2'b11; il = ill; end
                T_MEMADR: begin sa = 1; sb = 2'b10; end
                T_MEMRD:  iord = 1;
                T_MEMWB:  begin m2r = 1; rw = 1; end
                T_MEMWR:  begin iord = 1; mw = 1; end
                T_RTEXEC: begin sa = 1; aop = 2'b10; end
                T_RTWB:   begin rd = 1; rw = 1; end
                T_BRANCH: begin sa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
                T_IEXEC:  begin sa = 1; sb = 2'b10; aop = 2'b10; end
                T_IWB:    rw = 1;
                T_JUMP:   begin pcs = 2'b10; pcw = 1; end
                default:  ;
            endcase
        end
        return {iord, mw, irw, rd, m2r, rw, sa, sb, aop, pcs, pcw, br, il};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, AluSrcA,
                AluSrcB, AluOp, PCSrc, PCWrite, Branch, Illegal};
    endfunction

    // One clock cycle: drive inputs after the edge, predict, sample mid-cycle.
    task automatic step(input string tag, input tst_e st, input logic [5:0] op,
                        input logic mr, input logic rst, input logic ill);
        exp_t e;
        logic [15:0] got;
        @(posedge clk);
        #1;
        Op = op; MemReady = mr; reset = rst; Zero = $urandom_range(0, 1);
        step_n++;
        q.push_back('{tag: $sformatf("%s#%0d", tag, step_n), vec: exp_vec(st, mr, rst, ill)});
        #3;
        e = q.pop_front();
        got = dut_vec();
        total++;
        assert (got === e.vec) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", e.tag, got, e.vec);
        end
    endtask

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                           BEQ = 6'b000100, ADDI = 6'b001000, ORI = 6'b001101,
                           SLTI = 6'b001010, J = 6'b000010, BAD = 6'b111111;

    initial begin
        step("rst0", T_FETCH, RT, 1, 1, 0);
        step("rst1", T_FETCH, RT, 1, 1, 0);

        // sw stalled in MEMWR, then reset for two cycles with MemReady high
        step("swf",   T_FETCH,  SW, 1, 0, 0);
        step("swd",   T_DECODE, SW, 0, 0, 0);
        step("swa",   T_MEMADR, SW, 0, 0, 0);
        step("swwt",  T_MEMWR,  RT, 0, 0, 0);
        step("swrst", T_MEMWR,  SW, 1, 1, 0);
        step("swrs2", T_FETCH,  SW, 1, 1, 0);
        step("fwait", T_FETCH,  RT, 0, 0, 0);

        // R-type, with Op and MemReady wiggled where they must be ignored
        step("rtf",  T_FETCH,  RT,  1, 0, 0);
        step("rtd",  T_DECODE, RT,  0, 0, 0);
        step("rte",  T_RTEXEC, BAD, 0, 0, 0);
        step("rtw",  T_RTWB,   LW,  1, 0, 0);

        // lw with three MemReady-low cycles in MEMRD
        step("lwf",  T_FETCH,  LW, 1, 0, 0);
        step("lwd",  T_DECODE, LW, 1, 0, 0);
        step("lwa",  T_MEMADR, LW, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("lwwt", T_MEMRD, RT, 0, 0, 0);
        step("lwr",  T_MEMRD,  RT, 1, 0, 0);
        step("lwb",  T_MEMWB,  RT, 0, 0, 0);

        // sw single cycle write
        step("sw2f", T_FETCH,  SW, 1, 0, 0);
        step("sw2d", T_DECODE, SW, 0, 0, 0);
        step("sw2a", T_MEMADR, SW, 0, 0, 0);
        step("sw2w", T_MEMWR,  SW, 1, 0, 0);

        step("beqf", T_FETCH,  BEQ, 1, 0, 0);
        step("beqd", T_DECODE, BEQ, 0, 0, 0);
        step("beqb", T_BRANCH, BEQ, 0, 0, 0);

        step("jf",   T_FETCH,  J, 1, 0, 0);
        step("jd",   T_DECODE, J, 0, 0, 0);
        step("jj",   T_JUMP,   J, 0, 0, 0);

        step("adf",  T_FETCH,  ADDI, 1, 0, 0);
        step("add",  T_DECODE, ADDI, 0, 0, 0);
        step("ade",  T_IEXEC,  BAD,  0, 0, 0);
        step("adw",  T_IWB,    RT,   0, 0, 0);

        step("orf",  T_FETCH,  ORI, 1, 0, 0);
        step("ord",  T_DECODE, ORI, 0, 0, 0);
        step("ore",  T_IEXEC,  ORI, 0, 0, 0);
        step("orw",  T_IWB,    ORI, 0, 0, 0);

        // illegal opcode, then slti aborted by reset in IWB
        step("ilf",  T_FETCH,  BAD, 1, 0, 0);
        step("ild",  T_DECODE, BAD, 0, 0, 1);
        step("ilx",  T_FETCH,  BAD, 0, 0, 0);
        step("slf",  T_FETCH,  SLTI, 1, 0, 0);
        step("sld",  T_DECODE, SLTI, 0, 0, 0);
        step("sle",  T_IEXEC,  SLTI, 0, 0, 0);
        step("slr",  T_IWB,    SLTI, 1, 1, 0);
        step("slx",  T_FETCH,  SLTI, 1, 0, 0);
        step("sly",  T_DECODE, SLTI, 0, 0, 0);

        total++;
        assert (q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Main control state machine for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives every datapath enable and mux select. It also drives the 2-bit AluOp that selects between forced ALU operations and Op/Funct-derived ALU control. It waits on a memory-ready handshake for instruction and data accesses, and flags undefined opcodes.

## Interface
Parameters:
- none; opcode and state encodings come from the shared defines file.

Ports:
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high
- Op  in  6  instruction opcode, IR[31:26]; valid from DECODE onward
- MemReady  in  1  memory completes the current read or write this cycle
- Zero  in  1  ALU zero flag, used in BRANCH
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  register destination select: 0 = rt, 1 = rd
- MemtoReg  out  1  register write data select: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write enable
- AluSrcA  out  1  ALU A select: 0 = PC, 1 = A
- AluSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- AluOp  out  2  ALU operation class: 00 = add, 01 = sub, 10 = decode from Op/Funct
- PCSrc  out  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- PCWrite  out  1  unconditional PC write
- Branch  out  1  conditional PC write, qualified externally with Zero
- Illegal  out  1  one-cycle pulse when DECODE sees an unsupported Op

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, BRANCH, IEXEC, IWB, JUMP.
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - andi 001100
  - ori 001101
  - slti 001010
  - j 000010
- FETCH: IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00, PCSrc=00.
  - IRWrite and PCWrite are asserted only when MemReady=1; the state then moves to DECODE.
  - When MemReady=0, the state holds in FETCH.
- DECODE: AluSrcA=0, AluSrcB=11, AluOp=00 (precomputes the branch target). Next state by Op:
  - lw, sw → MEMADR
  - R-type → RTEXEC
  - beq → BRANCH
  - addi, andi, ori, slti → IEXEC
  - j → JUMP
  - any other Op → FETCH, with Illegal=1 for this cycle
- MEMADR: AluSrcA=1, AluSrcB=10, AluOp=00. Next state: lw → MEMRD, sw → MEMWR.
- MEMRD: IorD=1. Holds until MemReady=1, then → MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. → FETCH.
- MEMWR: IorD=1, MemWrite=1. Holds until MemReady=1, then → FETCH.
  - MemWrite stays high for every cycle spent in MEMWR.
- RTEXEC: AluSrcA=1, AluSrcB=00, AluOp=10. → RTWB.
- RTWB: RegDst=1, MemtoReg=0, RegWrite=1. → FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, PCSrc=01, Branch=1. → FETCH.
- IEXEC: AluSrcA=1, AluSrcB=10, AluOp=10. → IWB.
- IWB: RegDst=0, MemtoReg=0, RegWrite=1. → FETCH.
- JUMP: PCSrc=10, PCWrite=1. → FETCH.
- Any output not listed for a state is 0.

## Timing
- Outputs are decoded from the state register (Moore). The exceptions are IRWrite and PCWrite in FETCH, which are qualified by MemReady in the same cycle.
- Reset:
  - With reset high at a clock edge, the state becomes FETCH.
  - While reset is high, MemWrite, IRWrite, RegWrite, PCWrite, Branch and Illegal are forced to 0 regardless of state or MemReady.
  - All other outputs take their FETCH values.
- Reset asserted mid-instruction (any state) aborts the instruction. No write enable fires in the reset cycle; the next cycle is FETCH.
- Cycle counts, from entering FETCH with MemReady=1 on the first cycle:
  - j: 3
  - beq: 3
  - sw: 4
  - R-type: 4
  - immediate ops: 4
  - lw: 5
  - Each wait cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Op is sampled only in DECODE and MEMADR. Changes to Op in other states are ignored.
- MemReady outside FETCH, MEMRD and MEMWR is ignored.
- Illegal pulses high for exactly one cycle (the DECODE cycle). The following cycle is FETCH.

## Structure
- Shared defines file holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J)
  - 4-bit state encodings
  - AluOp codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
- The ALU control block also includes this defines file for its opcode constants.
- Natural split: one sub-module, mc_ctrl_outdec, a combinational map from state, MemReady and reset to the output bundle. The top holds the state register and next-state logic.

## Test plan
- Reset held 2 cycles during MEMWR with MemReady=1 → MemWrite=0 in both cycles; state FETCH after release; IorD=0, AluSrcB=01.
- R-type add (Op=000000), MemReady=1 → IRWrite and PCWrite in cycle 1; AluOp=10 in cycle 3; RegWrite=1 and RegDst=1 in cycle 4; FETCH in cycle 5.
- lw with MemReady low 3 cycles in MEMRD → IorD=1 held for 4 cycles; RegWrite=1 and MemtoReg=1 exactly once; total 8 cycles.
- sw with MemReady=1 → MemWrite=1 for exactly 1 cycle in cycle 4; RegWrite never asserted.
- beq → cycle 3 shows AluOp=01, PCSrc=01, Branch=1; j → cycle 3 shows PCWrite=1, PCSrc=10.
- Op=111111 → Illegal=1 for one cycle at DECODE; then FETCH; no RegWrite or MemWrite asserted.
